// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Shares one external multiplier between two request channels. Each channel
// captures a 16x8 operand pair on a start strobe while it is idle. Requests
// with a zero operand complete locally on the next edge with a zero product.
// All other requests are served one at a time through the shared multiplier.
// Simultaneous requests are arbitrated round-robin.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start0_i / start1_i      request strobe per channel
//   a0_bi / a1_bi  [15:0]    operand A per channel
//   b0_bi / b1_bi  [7:0]     operand B per channel
//   busy0_o / busy1_o        channel holds an accepted, uncompleted request
//   done0_o / done1_o        one-cycle completion pulse per channel
//   y0_bo / y1_bo  [23:0]    product per channel, held until next completion
//   grant_o        [1:0]     one-hot multiplier owner, 2'b00 when none
//   mult_a_bo      [15:0]    operand A to the shared multiplier
//   mult_b_bo      [7:0]     operand B to the shared multiplier
//   mult_start_o             multiplier start, high START_LEN cycles per op
//   mult_busy_i              multiplier busy
//   mult_y_bi      [23:0]    multiplier result
//
// Parameter
//   START_LEN (1..7)         cycles mult_start_o is held per operation
// -----------------------------------------------------------------------------
module mult_arbiter #(
  parameter int unsigned START_LEN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start0_i,
  input  logic        start1_i,
  input  logic [15:0] a0_bi,
  input  logic [15:0] a1_bi,
  input  logic [7:0]  b0_bi,
  input  logic [7:0]  b1_bi,
  output logic        busy0_o,
  output logic        busy1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [23:0] y0_bo,
  output logic [23:0] y1_bo,
  output logic [1:0]  grant_o,
  output logic [15:0] mult_a_bo,
  output logic [7:0]  mult_b_bo,
  output logic        mult_start_o,
  input  logic        mult_busy_i,
  input  logic [23:0] mult_y_bi
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Value of the issue counter on the last start cycle.
  localparam logic [2:0] LP_ISSUE_LAST = 3'(START_LEN - 1);

  // Channel inputs gathered into arrays so both channels share one code path.
  logic [1:0]  w_start;
  logic [15:0] w_a_in [2];
  logic [7:0]  w_b_in [2];

  assign w_start   = {start1_i, start0_i};
  assign w_a_in[0] = a0_bi;
  assign w_a_in[1] = a1_bi;
  assign w_b_in[0] = b0_bi;
  assign w_b_in[1] = b1_bi;

  // Per-channel request state.
  logic [1:0]  r_busy;  // accepted, not yet completed
  logic [1:0]  r_zero;  // accepted request has a zero operand
  logic [1:0]  r_done;
  logic [15:0] r_a [2];
  logic [7:0]  r_b [2];
  logic [23:0] r_y [2];

  // Arbiter state.
  state_t     r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic       r_last,  w_last_nxt;   // channel that completed most recently
  logic [2:0] r_cnt,   w_cnt_nxt;    // start cycles issued so far

  logic [1:0] w_req;       // channels waiting for the multiplier
  logic       w_complete;  // granted operation finishes on this edge

  assign w_req      = r_busy & ~r_zero;
  assign w_complete = (r_state == ST_WAIT) && !mult_busy_i;

  // ---------------------------------------------------------------------------
  // Channel registers: capture, zero shortcut and completion.
  // A busy channel can only complete, never recapture, so a start arriving on
  // the completion edge is ignored while one arriving in the done cycle is
  // accepted.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: the operand registers are reset too; they feed mult_a_bo/mult_b_bo
  // only through the grant mux, but a known value keeps reset behaviour clean.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= 2'b00;
      r_zero <= 2'b00;
      r_done <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        r_a[n] <= '0;
        r_b[n] <= '0;
        r_y[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        r_done[n] <= 1'b0;
        if (r_busy[n] && r_zero[n]) begin
          r_y[n]    <= '0;
          r_done[n] <= 1'b1;
          r_busy[n] <= 1'b0;
          r_zero[n] <= 1'b0;
        end else if (w_complete && r_grant[n]) begin
          r_y[n]    <= mult_y_bi;
          r_done[n] <= 1'b1;
          r_busy[n] <= 1'b0;
        end else if (w_start[n] && !r_busy[n]) begin
          r_a[n]    <= w_a_in[n];
          r_b[n]    <= w_b_in[n];
          r_busy[n] <= 1'b1;
          r_zero[n] <= (w_a_in[n] == 16'd0) || (w_b_in[n] == 8'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: state register.
  // Reset leaves channel 1 as last served so channel 0 wins the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM: next state. The grant decision uses registered busy flags,
  // so a request is never granted on its own capture edge.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req != 2'b00) begin
          w_state_nxt = ST_ISSUE;
          w_cnt_nxt   = '0;
          if (w_req == 2'b11) begin
            w_grant_nxt = r_last ? 2'b01 : 2'b10;
          end else begin
            w_grant_nxt = w_req;
          end
        end
      end
      ST_ISSUE: begin
        if (r_cnt == LP_ISSUE_LAST) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_WAIT: begin
        if (!mult_busy_i) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
          w_last_nxt  = r_grant[1];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier interface. The grant is zero exactly in IDLE, so selecting by
  // grant gives zero operands there and the owner's captured (and therefore
  // stable) operands through ISSUE and WAIT.
  // ---------------------------------------------------------------------------
  always_comb begin
    mult_a_bo = '0;
    mult_b_bo = '0;
    if (r_grant[0]) begin
      mult_a_bo = r_a[0];
      mult_b_bo = r_b[0];
    end else if (r_grant[1]) begin
      mult_a_bo = r_a[1];
      mult_b_bo = r_b[1];
    end
  end

  assign mult_start_o = (r_state == ST_ISSUE);
  assign grant_o      = r_grant;

  assign busy0_o = r_busy[0];
  assign busy1_o = r_busy[1];
  assign done0_o = r_done[0];
  assign done1_o = r_done[1];
  assign y0_bo   = r_y[0];
  assign y1_bo   = r_y[1];

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Directed scenarios plus randomized traffic for mult_arbiter. A behavioural
// multiplier drives mult_busy_i / mult_y_bi with a random latency. A
// transaction-level reference model predicts every output each cycle. It
// tracks outstanding requests per channel, round-robin ownership of the
// multiplier, and the number of start cycles issued for the current owner.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

  localparam int START_LEN = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start0_i, start1_i;
  logic [15:0] a0_bi, a1_bi;
  logic [7:0]  b0_bi, b1_bi;
  logic        busy0_o, busy1_o, done0_o, done1_o;
  logic [23:0] y0_bo, y1_bo;
  logic [1:0]  grant_o;
  logic [15:0] mult_a_bo;
  logic [7:0]  mult_b_bo;
  logic        mult_start_o;
  logic        mult_busy_i;
  logic [23:0] mult_y_bi;

  always #5 clk_i = ~clk_i;

  mult_arbiter #(.START_LEN(START_LEN)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start0_i     (start0_i),
    .start1_i     (start1_i),
    .a0_bi        (a0_bi),
    .a1_bi        (a1_bi),
    .b0_bi        (b0_bi),
    .b1_bi        (b1_bi),
    .busy0_o      (busy0_o),
    .busy1_o      (busy1_o),
    .done0_o      (done0_o),
    .done1_o      (done1_o),
    .y0_bo        (y0_bo),
    .y1_bo        (y1_bo),
    .grant_o      (grant_o),
    .mult_a_bo    (mult_a_bo),
    .mult_b_bo    (mult_b_bo),
    .mult_start_o (mult_start_o),
    .mult_busy_i  (mult_busy_i),
    .mult_y_bi    (mult_y_bi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_out [2];   // request accepted and not yet completed
  bit          m_zp  [2];   // accepted request is a zero-operand shortcut
  logic [15:0] m_a   [2];
  logic [7:0]  m_b   [2];
  logic [23:0] m_y   [2];
  logic [1:0]  m_grant;
  bit          m_start;     // expected mult_start_o in the current cycle
  int          m_srun;      // start cycles issued for the current owner
  int          m_last;      // channel served most recently

  // Inputs as presented to the most recent clock edge.
  bit          d_start [2];
  logic [15:0] d_a     [2];
  logic [7:0]  d_b     [2];

  // Behavioural multiplier.
  int mm_lat  = 0;
  int lat_min = 1;
  int lat_max = 4;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_out[n] = 0;
      m_zp[n]  = 0;
      m_a[n]   = '0;
      m_b[n]   = '0;
      m_y[n]   = '0;
    end
    m_grant     = 2'b00;
    m_start     = 0;
    m_srun      = 0;
    m_last      = 1;
    mm_lat      = 0;
    mult_busy_i = 1'b0;
    mult_y_bi   = '0;
  endtask

  // Advance the model over one clock edge and compare every output.
  task automatic monitor();
    logic [1:0]  exp_done, elig, exp_busy;
    logic [15:0] exp_ma;
    logic [7:0]  exp_mb;
    bit          comp_m;

    // The owner finishes once all start cycles are out and the multiplier is idle.
    comp_m = (m_grant != 2'b00) && !m_start && !mult_busy_i;
    for (int n = 0; n < 2; n++) begin
      elig[n]     = m_out[n] && !m_zp[n];
      exp_done[n] = m_zp[n] || (comp_m && m_grant[n]);
    end
    for (int n = 0; n < 2; n++) begin
      if (exp_done[n]) begin
        m_y[n]   = m_zp[n] ? 24'd0 : 24'(m_a[n]) * 24'(m_b[n]);
        m_out[n] = 0;
        m_zp[n]  = 0;
      end else if (d_start[n] && !m_out[n]) begin
        m_out[n] = 1;
        m_a[n]   = d_a[n];
        m_b[n]   = d_b[n];
        m_zp[n]  = (d_a[n] == 16'd0) || (d_b[n] == 8'd0);
      end
    end
    if (m_grant == 2'b00) begin
      if (elig == 2'b11) m_grant = (m_last == 1) ? 2'b01 : 2'b10;
      else               m_grant = elig;
      m_srun = 0;
    end else if (comp_m) begin
      m_last  = m_grant[1] ? 1 : 0;
      m_grant = 2'b00;
    end
    m_start = (m_grant != 2'b00) && (m_srun < START_LEN);
    if (m_start) m_srun++;

    exp_busy = {m_out[1], m_out[0]};
    exp_ma   = m_grant[0] ? m_a[0] : (m_grant[1] ? m_a[1] : 16'd0);
    exp_mb   = m_grant[0] ? m_b[0] : (m_grant[1] ? m_b[1] : 8'd0);

    n_tests++;
    if ({busy1_o, busy0_o} !== exp_busy) begin
      n_fail++;
      $display("FAIL busy @%0t: got %b required %b", $time, {busy1_o, busy0_o}, exp_busy);
    end
    n_tests++;
    if ({done1_o, done0_o} !== exp_done) begin
      n_fail++;
      $display("FAIL done @%0t: got %b required %b", $time, {done1_o, done0_o}, exp_done);
    end
    n_tests++;
    if (y0_bo !== m_y[0]) begin
      n_fail++;
      $display("FAIL y0 @%0t: got %0d required %0d", $time, y0_bo, m_y[0]);
    end
    n_tests++;
    if (y1_bo !== m_y[1]) begin
      n_fail++;
      $display("FAIL y1 @%0t: got %0d required %0d", $time, y1_bo, m_y[1]);
    end
    n_tests++;
    if (grant_o !== m_grant) begin
      n_fail++;
      $display("FAIL grant @%0t: got %b required %b", $time, grant_o, m_grant);
    end
    n_tests++;
    if (mult_start_o !== m_start) begin
      n_fail++;
      $display("FAIL mult_start @%0t: got %b required %b", $time, mult_start_o, m_start);
    end
    n_tests++;
    if (mult_a_bo !== exp_ma) begin
      n_fail++;
      $display("FAIL mult_a @%0t: got %0d required %0d", $time, mult_a_bo, exp_ma);
    end
    n_tests++;
    if (mult_b_bo !== exp_mb) begin
      n_fail++;
      $display("FAIL mult_b @%0t: got %0d required %0d", $time, mult_b_bo, exp_mb);
    end
  endtask

  // Multiplier: busy from the first start cycle until a random number of
  // cycles after the last one. The result is garbage until it drops busy.
  task automatic mult_model();
    if (mult_start_o) begin
      mult_busy_i = 1'b1;
      mm_lat      = int'($urandom_range(lat_max, lat_min));
      mult_y_bi   = 24'($urandom);
    end else if (mm_lat > 0) begin
      mm_lat--;
      if (mm_lat == 0) begin
        mult_busy_i = 1'b0;
        mult_y_bi   = 24'(mult_a_bo) * 24'(mult_b_bo);
      end
    end
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step();
    d_start[0] = start0_i;
    d_start[1] = start1_i;
    d_a[0] = a0_bi;
    d_a[1] = a1_bi;
    d_b[0] = b0_bi;
    d_b[1] = b1_bi;
    @(posedge clk_i);
    @(negedge clk_i);
    monitor();
    mult_model();
    start0_i = 1'b0;
    start1_i = 1'b0;
  endtask

  task automatic req(input int ch, input logic [15:0] a, input logic [7:0] b);
    if (ch == 0) begin
      start0_i = 1'b1;
      a0_bi    = a;
      b0_bi    = b;
    end else begin
      start1_i = 1'b1;
      a1_bi    = a;
      b1_bi    = b;
    end
  endtask

  task automatic run_until_done(input int ch, input int max_cyc, output bit seen,
                                output int starts, output logic [1:0] first_grant);
    seen        = 0;
    starts      = 0;
    first_grant = 2'b00;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (mult_start_o) begin
        if (starts == 0) first_grant = grant_o;
        starts++;
      end
      if ((ch == 0 && done0_o) || (ch == 1 && done1_o)) seen = 1;
    end
  endtask

  function automatic logic [15:0] rand_a();
    case ($urandom_range(9, 0))
      0:       return 16'd0;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rand_b();
    case ($urandom_range(9, 0))
      0:       return 8'd0;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if ({busy1_o, busy0_o, done1_o, done0_o, mult_start_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {busy1_o, busy0_o, done1_o, done0_o, mult_start_o});
    end
    n_tests++;
    if (grant_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_grant: got %b required 00", grant_o);
    end
    n_tests++;
    if (y0_bo !== 24'd0 || y1_bo !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_y: got %0d/%0d required 0/0", y0_bo, y1_bo);
    end
    n_tests++;
    if (mult_a_bo !== 16'd0 || mult_b_bo !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_operands: got %0d/%0d required 0/0", mult_a_bo, mult_b_bo);
    end
    rst_i = 1'b0;
    model_reset();
    repeat (3) step();
  endtask

  task automatic test_pair();
    bit seen;
    int starts;
    logic [1:0] fg;
    req(0, 16'd2, 8'd7);
    req(1, 16'd100, 8'd200);
    run_until_done(0, 60, seen, starts, fg);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL pair_done0: got timeout required done0 pulse");
    end
    n_tests++;
    if (fg !== 2'b01) begin
      n_fail++;
      $display("FAIL pair_grant0: got %b required 01", fg);
    end
    n_tests++;
    if (y0_bo !== 24'd14) begin
      n_fail++;
      $display("FAIL pair_y0: got %0d required 14", y0_bo);
    end
    n_tests++;
    if (busy1_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pair_queued1: got busy1=%b required 1", busy1_o);
    end
    run_until_done(1, 60, seen, starts, fg);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL pair_done1: got timeout required done1 pulse");
    end
    n_tests++;
    if (fg !== 2'b10) begin
      n_fail++;
      $display("FAIL pair_grant1: got %b required 10", fg);
    end
    n_tests++;
    if (y1_bo !== 24'd20000) begin
      n_fail++;
      $display("FAIL pair_y1: got %0d required 20000", y1_bo);
    end
  endtask

  task automatic test_single();
    bit seen;
    int starts;
    logic [1:0] fg;
    req(0, 16'd3, 8'd5);
    run_until_done(0, 60, seen, starts, fg);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL single_done: got timeout required done0 pulse");
    end
    n_tests++;
    if (starts != START_LEN) begin
      n_fail++;
      $display("FAIL single_start_len: got %0d required %0d", starts, START_LEN);
    end
    n_tests++;
    if (y0_bo !== 24'd15) begin
      n_fail++;
      $display("FAIL single_y0: got %0d required 15", y0_bo);
    end
    step();
    n_tests++;
    if (done0_o !== 1'b0 || busy0_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got done0=%b busy0=%b required 0/0", done0_o, busy0_o);
    end
  endtask

  task automatic test_zero();
    req(1, 16'd0, 8'd9);
    step();
    n_tests++;
    if (busy1_o !== 1'b1 || grant_o !== 2'b00 || mult_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_capture: got busy1=%b grant=%b start=%b required 1/00/0",
               busy1_o, grant_o, mult_start_o);
    end
    step();
    n_tests++;
    if (done1_o !== 1'b1 || y1_bo !== 24'd0) begin
      n_fail++;
      $display("FAIL zero_done: got done1=%b y1=%0d required 1/0", done1_o, y1_bo);
    end
    step();
    n_tests++;
    if (done1_o !== 1'b0 || busy1_o !== 1'b0 || grant_o !== 2'b00 || mult_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: got done1=%b busy1=%b grant=%b start=%b required 0/0/00/0",
               done1_o, busy1_o, grant_o, mult_start_o);
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int starts;
    logic [1:0] fg;
    req(0, 16'd1, 8'd1);
    req(1, 16'd4, 8'd4);
    run_until_done(1, 60, seen, starts, fg);
    n_tests++;
    if (!seen || fg !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_first: got seen=%0d grant=%b required 1/10", seen, fg);
    end
    n_tests++;
    if (y1_bo !== 24'd16) begin
      n_fail++;
      $display("FAIL rr_y1: got %0d required 16", y1_bo);
    end
    run_until_done(0, 60, seen, starts, fg);
    n_tests++;
    if (!seen || fg !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_second: got seen=%0d grant=%b required 1/01", seen, fg);
    end
    n_tests++;
    if (y0_bo !== 24'd1) begin
      n_fail++;
      $display("FAIL rr_y0: got %0d required 1", y0_bo);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int starts;
    logic [1:0] fg;
    req(0, 16'd65535, 8'd255);
    run_until_done(0, 60, seen, starts, fg);
    n_tests++;
    if (!seen || y0_bo !== 24'd16711425) begin
      n_fail++;
      $display("FAIL extreme_y0: got seen=%0d y0=%0d required 1/16711425", seen, y0_bo);
    end
    // Re-request while done0_o is high.
    req(0, 16'd1234, 8'd56);
    step();
    n_tests++;
    if (busy0_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rerequest_accept: got busy0=%b required 1", busy0_o);
    end
    run_until_done(0, 60, seen, starts, fg);
    n_tests++;
    if (!seen || y0_bo !== 24'd69104) begin
      n_fail++;
      $display("FAIL rerequest_y0: got seen=%0d y0=%0d required 1/69104", seen, y0_bo);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit in_wait;
    int starts;
    int dones;
    logic [1:0] fg;
    lat_min = 6;
    lat_max = 6;
    req(0, 16'd500, 8'd3);
    step();
    step();
    req(1, 16'd9, 8'd9);
    in_wait = 0;
    for (int i = 0; i < 40 && !in_wait; i++) begin
      step();
      if (grant_o != 2'b00 && !mult_start_o) in_wait = 1;
    end
    n_tests++;
    if (!in_wait || busy1_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: got wait=%0d busy1=%b required 1/1", in_wait, busy1_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if ({busy1_o, busy0_o, done1_o, done0_o, mult_start_o, grant_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b required 0000000",
               {busy1_o, busy0_o, done1_o, done0_o, mult_start_o, grant_o});
    end
    n_tests++;
    if (y0_bo !== 24'd0 || y1_bo !== 24'd0 || mult_a_bo !== 16'd0 || mult_b_bo !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_data: got y0=%0d y1=%0d a=%0d b=%0d required 0",
               y0_bo, y1_bo, mult_a_bo, mult_b_bo);
    end
    model_reset();
    lat_min = 1;
    lat_max = 4;
    @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0;
    repeat (10) begin
      step();
      dones += int'(done0_o) + int'(done1_o);
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d pulses required 0", dones);
    end
    req(1, 16'd7, 8'd8);
    run_until_done(1, 60, seen, starts, fg);
    n_tests++;
    if (!seen || y1_bo !== 24'd56) begin
      n_fail++;
      $display("FAIL midreset_recover: got seen=%0d y1=%0d required 1/56", seen, y1_bo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) < 35) req(0, rand_a(), rand_b());
      if ($urandom_range(99, 0) < 35) req(1, rand_a(), rand_b());
      step();
    end
    for (int i = 0; i < 200 && (busy0_o || busy1_o); i++) step();
    n_tests++;
    if (busy0_o !== 1'b0 || busy1_o !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got busy=%b%b required 00", busy1_o, busy0_o);
    end
  endtask

  initial begin
    start0_i = 1'b0;
    start1_i = 1'b0;
    a0_bi    = '0;
    a1_bi    = '0;
    b0_bi    = '0;
    b1_bi    = '0;
    rst_i    = 1'b1;
    model_reset();

    test_reset();
    test_pair();
    test_single();
    test_zero();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: START_LEN, default 2, number of consecutive cycles mult_start_o is held high per issued operation (range 1..7).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 start0_i / start1_i  input  1  request strobe, channel 0 / 1.
REQ-005 a0_bi / a1_bi  input  16  operand A, channel 0 / 1.
REQ-006 b0_bi / b1_bi  input  8  operand B, channel 0 / 1.
REQ-007 busy0_o / busy1_o  output  1  channel has an accepted, uncompleted request.
REQ-008 done0_o / done1_o  output  1  one-cycle completion pulse, channel 0 / 1.
REQ-009 y0_bo / y1_bo  output  24  product for channel 0 / 1, held until next completion on that channel.
REQ-010 grant_o  output  2  one-hot owner of the shared multiplier; 2'b00 when no owner.
REQ-011 mult_a_bo  output  16, mult_b_bo  output  8: operands to the shared multiplier.
REQ-012 mult_start_o  output  1: multiplier start.
REQ-013 mult_busy_i  input  1, mult_y_bi  input  24: multiplier busy and result.

Function
REQ-014 Per channel: start_n_i sampled high while busy_n_o=0 captures a_n/b_n into channel registers on that edge; start_n_i while busy_n_o=1 is ignored.
REQ-015 Zero shortcut: a captured request with a=0 or b=0 does not use the multiplier; on the next edge y_n_bo<=0 and done_n_o pulses. busy_n_o is high for exactly that one cycle.
REQ-016 A nonzero request sets busy_n_o=1 from the capture edge until the completion edge.
REQ-017 Arbiter FSM states: IDLE, ISSUE, WAIT.
REQ-018 IDLE: with any channel busy (nonzero request) grant that channel; with both busy grant the channel not granted last (last_grant register). Transition to ISSUE and set grant_o one-hot. Operand capture and grant never occur on the same edge, so IDLE grants at earliest one cycle after capture.
REQ-019 ISSUE: mult_a_bo/mult_b_bo = granted channel's operands; mult_start_o=1 for exactly START_LEN cycles, then transition to WAIT with mult_start_o=0.
REQ-020 WAIT: on the first edge with mult_busy_i=0, y_n_bo<=mult_y_bi, done_n_o pulses the following cycle, busy_n_o clears, last_grant<=n, grant_o<=2'b00, state<=IDLE.
REQ-021 mult_a_bo/mult_b_bo remain stable from ISSUE entry through WAIT exit; they are 0 in IDLE.
REQ-022 A new start_n_i is accepted in the cycle done_n_o is high (busy_n_o already low).
REQ-023 Requests from the non-granted channel captured during ISSUE/WAIT are queued and served in the next IDLE cycle; no request is ever dropped.
REQ-024 Arbiter throughput: one IDLE cycle between consecutive multiplier operations; grant cannot change while state != IDLE.

Reset
REQ-025 rst_i high asynchronously forces state=IDLE, grant_o=0, mult_start_o=0, mult_a_bo=0, mult_b_bo=0, busy*_o=0, done*_o=0, y*_bo=0, last_grant=channel 1 (so channel 0 wins the first tie).
REQ-026 Reset mid-ISSUE/WAIT discards the in-flight operation and all captured requests; no done pulse is generated for them. The shared multiplier shares rst_i.

Verification
REQ-027 Single request ch0 a=3,b=5 -> mult_start_o high START_LEN cycles, y0_bo=15, one done0_o pulse, busy0_o low after.
REQ-028 Same-cycle requests ch0 (2,7) and ch1 (100,200) after reset -> ch0 served first y0_bo=14, then ch1 y1_bo=20000; grant_o 01 then 10.
REQ-029 Second simultaneous pair ch0 (1,1), ch1 (4,4) -> ch1 served first (round-robin) y1_bo=16, then y0_bo=1.
REQ-030 ch1 a=0,b=9 -> y1_bo=0, done1_o one cycle after capture, mult_start_o never asserted, grant_o stays 00.
REQ-031 Extreme operands ch0 a=65535,b=255 -> y0_bo=16711425; re-request on done cycle accepted.
REQ-032 Assert rst_i asynchronously during WAIT with ch1 queued -> all outputs 0 immediately, no done pulses after release, next request served normally.
